// File: rtl/conv_window_streamer.sv
// conv_window_streamer: K x K sliding-window generator over a padded plane.
// Optional out_zero flag is built when WIN_ZERO_FLAG_EN is defined.
module conv_window_streamer #(
  parameter int W  = 30,
  parameter int K  = 3,
  parameter int S  = 1,
  parameter int BW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BW-1:0]          in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [K*K*BW-1:0]      out_window,
  output logic [$clog2(W)-1:0]   out_row,
  output logic [$clog2(W)-1:0]   out_col,
  output logic                   out_last
`ifdef WIN_ZERO_FLAG_EN
  ,
  output logic                   out_zero
`endif
);

  localparam int CW = $clog2(W);
  localparam int PW = (S > 1) ? $clog2(S) : 1;
  localparam logic [CW-1:0] PIX_MAX = CW'(W - 1);
  localparam logic [CW-1:0] KM1 = CW'(K - 1);
  localparam logic [CW-1:0] KM2 = CW'(K - 2);
  localparam logic [PW-1:0] PH_MAX = PW'(S - 1);

  if (((W - K) % S) != 0 || W < K || K < 2 || S < 1) begin : g_bad_cfg
    $error("conv_window_streamer: need W>=K, K>=2, S>=1, (W-K)%%S==0");
  end

  typedef enum logic {FILL, RUN} state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] pix_col;
  logic [CW-1:0] pix_row;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [PW-1:0] col_ph;
  logic [PW-1:0] row_ph;

  logic [BW-1:0] lbuf [K-1][W];
  logic [BW-1:0] win [K][K];
  logic [BW-1:0] win_nxt [K][K];
  logic [K*K*BW-1:0] win_flat;

  logic accept;
  logic col_end;
  logic row_end;
  logic due;
  logic last;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign col_end  = pix_col == PIX_MAX;
  assign row_end  = pix_row == PIX_MAX;
  assign due      = (state == RUN) && (pix_row >= KM1) &&
                    (pix_col >= KM1) &&
                    (col_ph == '0) && (row_ph == '0);
  assign last     = due && col_end && row_end;

  // Next window: shift left, new right column from line buffers + input.
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_nxt[r][K-1] = lbuf[r][pix_col];
    end
    win_nxt[K-1][K-1] = in_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[((r*K+c)+1)*BW-1 -: BW] = win_nxt[r][c];
      end
    end
  end

`ifdef WIN_ZERO_FLAG_EN
  logic zero_nxt;

  // Window is all +0/-0 when no word has a nonzero magnitude bit.
  always_comb begin
    zero_nxt = 1'b1;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (|win_nxt[r][c][BW-2:0]) zero_nxt = 1'b0;
      end
    end
  end
`endif

  // Window shift register and line buffers; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_nxt;
      for (int i = 0; i < K - 2; i++) begin
        lbuf[i][pix_col] <= lbuf[i+1][pix_col];
      end
      lbuf[K-2][pix_col] <= in_data;
    end
  end

  // Pixel position, stride phases and window index counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_col <= '0;
      pix_row <= '0;
      col_ph  <= '0;
      row_ph  <= '0;
      win_col <= '0;
      win_row <= '0;
    end else if (accept) begin
      if (col_end) begin
        pix_col <= '0;
        col_ph  <= '0;
        win_col <= '0;
        if (row_end) begin
          pix_row <= '0;
          row_ph  <= '0;
          win_row <= '0;
        end else begin
          pix_row <= pix_row + 1'b1;
          if (pix_row >= KM1) begin
            if (row_ph == PH_MAX) begin
              row_ph  <= '0;
              win_row <= win_row + 1'b1;
            end else begin
              row_ph <= row_ph + 1'b1;
            end
          end
        end
      end else begin
        pix_col <= pix_col + 1'b1;
        if (pix_col >= KM1) begin
          if (col_ph == PH_MAX) begin
            col_ph  <= '0;
            win_col <= win_col + 1'b1;
          end else begin
            col_ph <= col_ph + 1'b1;
          end
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // FILL until K-1 rows are buffered, RUN until the frame's last pixel.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && col_end && pix_row == KM2) state_nxt = RUN;
      RUN:  if (accept && col_end && row_end) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Output register: load on a due window, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
      out_last   <= 1'b0;
`ifdef WIN_ZERO_FLAG_EN
      out_zero   <= 1'b0;
`endif
    end else if (accept && due) begin
      out_valid  <= 1'b1;
      out_window <= win_flat;
      out_row    <= win_row;
      out_col    <= win_col;
      out_last   <= last;
`ifdef WIN_ZERO_FLAG_EN
      out_zero   <= zero_nxt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// tb_conv_window_streamer: directed stimulus against a plane-level window
// model, for W=5 K=3 at strides 1 and 2.
module tb_conv_window_streamer;

  localparam int W  = 5;
  localparam int K  = 3;
  localparam int BW = 16;
  localparam int CW = $clog2(W);
  localparam int WB = K * K * BW;
  localparam int NWIN = W - K + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WB-1:0] out_window;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  logic          in_valid2 = 1'b0;
  logic          in_ready2;
  logic          out_valid2;
  logic          out_ready2 = 1'b1;
  logic [WB-1:0] out_window2;
  logic [CW-1:0] out_row2;
  logic [CW-1:0] out_col2;
  logic          out_last2;

`ifdef WIN_ZERO_FLAG_EN
  logic out_zero;
  logic out_zero2;
`endif

  conv_window_streamer #(.W(W), .K(K), .S(1), .BW(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_window(out_window), .out_row(out_row),
    .out_col(out_col), .out_last(out_last)
`ifdef WIN_ZERO_FLAG_EN
    , .out_zero(out_zero)
`endif
  );

  conv_window_streamer #(.W(W), .K(K), .S(2), .BW(BW)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_window(out_window2), .out_row(out_row2),
    .out_col(out_col2), .out_last(out_last2)
`ifdef WIN_ZERO_FLAG_EN
    , .out_zero(out_zero2)
`endif
  );

  typedef struct {
    logic [WB-1:0] win;
    int            row;
    int            col;
    bit            last;
    bit            zero;
  } win_t;

  win_t expq[$];
  win_t got[$];
  win_t got2[$];
  logic [BW-1:0] plane [W][W];

  int total = 0;
  int bad = 0;
  int bubble_pct = 0;
  bit rmode = 1'b0;
  bit mon1 = 1'b0;
  bit saw_low = 1'b0;
  bit hold = 1'b0;
  win_t held;

  task automatic chk(input string nm, input logic [WB-1:0] act,
                     input logic [WB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Every S=1 window of the current plane, in raster order.
  task automatic model_frame();
    for (int wr = 0; wr < NWIN; wr++) begin
      for (int wc = 0; wc < NWIN; wc++) begin
        win_t e;
        e.win = '0;
        e.zero = 1'b1;
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K; c++) begin
            logic [BW-1:0] v;
            v = plane[wr+r][wc+c];
            e.win[(r*K+c)*BW +: BW] = v;
            if (v[BW-2:0] != '0) e.zero = 1'b0;
          end
        end
        e.row = wr;
        e.col = wc;
        e.last = (wr == NWIN - 1) && (wc == NWIN - 1);
        expq.push_back(e);
      end
    end
  endtask

  task automatic push(input logic [BW-1:0] v, input bit to2);
    int t;
    t = 0;
    while (bubble_pct > 0 && $urandom_range(99) < bubble_pct) begin
      in_valid = 1'b0;
      in_valid2 = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_valid2 = to2;
    in_data = v;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("push_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic stream_plane(input int from, input int to, input bit to2);
    for (int i = from; i < to; i++) push(plane[i / W][i % W], to2);
  endtask

  task automatic fill_seq(input int base);
    for (int i = 0; i < W * W; i++) plane[i / W][i % W] = BW'(base + 1 + i);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Randomised consumer when rmode is set.
  always @(posedge clk) begin
    #1;
    if (rmode) out_ready = 1'($urandom_range(1));
  end

  // Main compare: model on every consumed window, stability under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (mon1 && !in_ready) saw_low = 1'b1;
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_window", out_window, held.win);
        chk("hold_row", out_row, held.row);
        chk("hold_col", out_col, held.col);
        chk("hold_last", out_last, held.last);
      end
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        hold = 1'b1;
        held.win = out_window;
        held.row = out_row;
        held.col = out_col;
        held.last = out_last;
      end else begin
        hold = 1'b0;
      end
      if (out_valid && out_ready) begin
        win_t g;
        bit ne;
        g.win = out_window;
        g.row = out_row;
        g.col = out_col;
        g.last = out_last;
        g.zero = 1'b0;
`ifdef WIN_ZERO_FLAG_EN
        g.zero = out_zero;
`endif
        got.push_back(g);
        ne = expq.size() != 0;
        chk("window_expected", ne, 1);
        if (ne) begin
          win_t e;
          e = expq.pop_front();
          chk("window", g.win, e.win);
          chk("row", g.row, e.row);
          chk("col", g.col, e.col);
          chk("last", g.last, e.last);
`ifdef WIN_ZERO_FLAG_EN
          chk("zero", g.zero, e.zero);
`endif
        end
      end
    end
  end

  // Stride-2 instance always consumes; log each window it shows.
  always @(negedge clk) begin
    if (rst_n && out_valid2) begin
      win_t g;
      g.win = out_window2;
      g.row = out_row2;
      g.col = out_col2;
      g.last = out_last2;
      g.zero = 1'b0;
      got2.push_back(g);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [WB-1:0] w_first;
  logic [WB-1:0] w_last;

  initial begin
    w_first = {16'd13, 16'd12, 16'd11, 16'd8, 16'd7,
               16'd6, 16'd3, 16'd2, 16'd1};
    w_last  = {16'd25, 16'd24, 16'd23, 16'd20, 16'd19,
               16'd18, 16'd15, 16'd14, 16'd13};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_window", out_window, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(2);

    // Continuous stream, S=1 and S=2 in parallel.
    fill_seq(0);
    model_frame();
    got.delete();
    got2.delete();
    mon1 = 1'b1;
    stream_plane(0, 12, 1'b1);
    chk("pre_first_valid", out_valid, 0);
    stream_plane(12, 13, 1'b1);
    chk("first_valid_lat1", out_valid, 1);
    chk("first_window", out_window, w_first);
    chk("first_row", out_row, 0);
    chk("first_col", out_col, 0);
    stream_plane(13, 25, 1'b1);
    chk("last_valid", out_valid, 1);
    chk("last_window", out_window, w_last);
    chk("last_flag", out_last, 1);
    chk("last_row", out_row, 2);
    chk("last_col", out_col, 2);
    idle(4);
    mon1 = 1'b0;
    chk("s1_in_ready_low_seen", saw_low, 0);
    chk("s1_count", got.size(), 9);
    chk("s1_queue_left", expq.size(), 0);
    chk("s2_count", got2.size(), 4);
    if (got2.size() == 4) begin
      int tl [4];
      int rr [4];
      int cc [4];
      tl = '{1, 3, 11, 13};
      rr = '{0, 0, 1, 1};
      cc = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
        chk("s2_topleft", got2[i].win[BW-1:0], tl[i]);
        chk("s2_row", got2[i].row, rr[i]);
        chk("s2_col", got2[i].col, cc[i]);
        chk("s2_last", got2[i].last, i == 3);
      end
    end

    // Backpressure at the first window for 4 cycles.
    fill_seq(0);
    model_frame();
    got.delete();
    out_ready = 1'b0;
    fork
      stream_plane(0, 25, 1'b0);
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
          t++;
          @(negedge clk);
        end
        chk("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
          chk("bp_in_ready", in_ready, 0);
          chk("bp_window", out_window, w_first);
          if (i < 3) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_count", got.size(), 9);
    chk("bp_queue_left", expq.size(), 0);

    // Random bubbles and consumer over two back-to-back frames.
    got.delete();
    fill_seq(0);
    model_frame();
    fill_seq(100);
    model_frame();
    bubble_pct = 50;
    rmode = 1'b1;
    fill_seq(0);
    stream_plane(0, 25, 1'b0);
    fill_seq(100);
    stream_plane(0, 25, 1'b0);
    bubble_pct = 0;
    rmode = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("rnd_count", got.size(), 18);
    chk("rnd_queue_left", expq.size(), 0);
    if (got.size() > 9) chk("rnd_f2_topleft", got[9].win[BW-1:0], 101);

    // Reset part way through a frame.
    fill_seq(0);
    stream_plane(0, 12, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_window", out_window, 0);
    chk("mid_rst_row", out_row, 0);
    chk("mid_rst_col", out_col, 0);
    chk("mid_rst_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    got.delete();
    model_frame();
    stream_plane(0, 25, 1'b0);
    idle(4);
    chk("post_rst_count", got.size(), 9);
    if (got.size() > 0) chk("post_rst_first", got[0].win, w_first);

`ifdef WIN_ZERO_FLAG_EN
    // Signed-zero border around a 1.0 interior, then an all-zero plane.
    begin
      int nz;
      for (int r = 0; r < W; r++) begin
        for (int c = 0; c < W; c++) begin
          if (r == 0 || c == 0 || r == W - 1 || c == W - 1)
            plane[r][c] = ((r + c) % 2 == 0) ? 16'h0000 : 16'h8000;
          else
            plane[r][c] = 16'h3F80;
        end
      end
      got.delete();
      model_frame();
      stream_plane(0, 25, 1'b0);
      idle(4);
      nz = 0;
      foreach (got[i]) if (got[i].zero) nz++;
      chk("zf_border_count", got.size(), 9);
      chk("zf_border_zeros", nz, 0);
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++)
          plane[r][c] = (c % 2 == 0) ? 16'h0000 : 16'h8000;
      got.delete();
      model_frame();
      stream_plane(0, 25, 1'b0);
      idle(4);
      nz = 0;
      foreach (got[i]) if (got[i].zero) nz++;
      chk("zf_allzero_zeros", nz, 9);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
